// File: rtl/binning_n_if.sv
// Pixel-stream bundle for binning_n: raster input fields plus binned output fields.
// Widths are derived from the same parameters the binner uses, so both must be instantiated alike.
interface binning_n_if #(
    parameter int HRES        = 1280,
    parameter int VRES        = 720,
    parameter int DATA_WIDTH  = 1,
    parameter int KERNEL_SIZE = 4
);
    localparam int LK        = $clog2(KERNEL_SIZE);
    localparam int HWIDTH    = $clog2(HRES);
    localparam int VWIDTH    = $clog2(VRES);
    localparam int SUM_WIDTH = DATA_WIDTH + 2 * LK;

    logic [HWIDTH-1:0]    hcount_in;
    logic [VWIDTH-1:0]    vcount_in;
    logic [DATA_WIDTH-1:0] pixel_data_in;
    logic                 data_valid_in;
    logic [1:0]           mode_in;
    logic [SUM_WIDTH-1:0] threshold_in;

    logic [DATA_WIDTH-1:0]  pixel_data_out;
    logic [HWIDTH-LK-1:0]   hcount_out;
    logic [VWIDTH-LK-1:0]   vcount_out;
    logic                   data_valid_out;
    logic                   frame_done_out;

    modport slave (
        input  hcount_in, vcount_in, pixel_data_in, data_valid_in, mode_in, threshold_in,
        output pixel_data_out, hcount_out, vcount_out, data_valid_out, frame_done_out
    );

    modport master (
        output hcount_in, vcount_in, pixel_data_in, data_valid_in, mode_in, threshold_in,
        input  pixel_data_out, hcount_out, vcount_out, data_valid_out, frame_done_out
    );
endinterface

// File: rtl/binning_n.sv
// Raster-stream KxK block binner: horizontal fold register, one accumulator line of HRES/K
// entries, and a three-stage output pipeline applying threshold / mean / max per frame.
module binning_n #(
    parameter int HRES        = 1280,
    parameter int VRES        = 720,
    parameter int DATA_WIDTH  = 1,
    parameter int KERNEL_SIZE = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    binning_n_if.slave  bus
);
    localparam int LK        = $clog2(KERNEL_SIZE);
    localparam int HWIDTH    = $clog2(HRES);
    localparam int VWIDTH    = $clog2(VRES);
    localparam int SUM_WIDTH = DATA_WIDTH + 2 * LK;
    localparam int ENTRIES   = HRES / KERNEL_SIZE;
    localparam int AWIDTH    = HWIDTH - LK;
    localparam int BWIDTH    = VWIDTH - LK;

    localparam logic [1:0] MODE_THRESH = 2'd0;
    localparam logic [1:0] MODE_MEAN   = 2'd1;
    localparam logic [1:0] MODE_MAX    = 2'd2;

    // Max in mode 2, sum otherwise (mode 3 behaves as threshold).
    function automatic logic [SUM_WIDTH-1:0] fold(input logic [1:0] mode,
                                                  input logic [SUM_WIDTH-1:0] a,
                                                  input logic [SUM_WIDTH-1:0] b);
        if (mode == MODE_MAX)
            return (a > b) ? a : b;
        return a + b;
    endfunction

    logic                  in_range;
    logic                  pix_ok;
    logic [LK-1:0]         grp_idx;
    logic [LK-1:0]         row_idx;
    logic [AWIDTH-1:0]     addr;
    logic [BWIDTH-1:0]     vblk;
    logic [SUM_WIDTH-1:0]  pix_ext;
    logic                  group_end;
    logic                  emit;
    logic                  last_blk;

    assign in_range  = (int'(bus.hcount_in) < HRES) && (int'(bus.vcount_in) < VRES);
    assign pix_ok    = bus.data_valid_in && in_range;
    assign grp_idx   = bus.hcount_in[LK-1:0];
    assign row_idx   = bus.vcount_in[LK-1:0];
    assign addr      = bus.hcount_in[HWIDTH-1:LK];
    assign vblk      = bus.vcount_in[VWIDTH-1:LK];
    assign pix_ext   = SUM_WIDTH'(bus.pixel_data_in);
    assign group_end = pix_ok && (grp_idx == '1);
    assign last_blk  = (addr == AWIDTH'(ENTRIES - 1)) && (vblk == BWIDTH'(VRES / KERNEL_SIZE - 1));

    logic [1:0]            mode_q;
    logic [SUM_WIDTH-1:0]  thr_q;
    logic                  primed;
    logic [SUM_WIDTH-1:0]  h_acc;
    logic [SUM_WIDTH-1:0]  rd_q;
    logic [SUM_WIDTH-1:0]  mem [ENTRIES];

    // Emission needs primed from an earlier pixel; row index K-1 can never be the priming pixel.
    assign emit = group_end && primed && (row_idx == '1);

    logic [SUM_WIDTH-1:0]  grp;
    logic [SUM_WIDTH-1:0]  blk;
    logic [DATA_WIDTH-1:0] res;

    // NOTE: every signal assigned in always_comb gets a value on entry so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        grp = fold(mode_q, h_acc, pix_ext);
        blk = fold(mode_q, rd_q, grp);
        res = '0;
        case (mode_q)
            MODE_MEAN: res = blk[SUM_WIDTH-1:2*LK];
            MODE_MAX:  res = blk[DATA_WIDTH-1:0];
            default:   res = (blk > thr_q) ? '1 : '0;
        endcase
    end

    // NOTE: the accumulator line carries no reset; the row-index-0 overwrite discards stale
    // contents, so a reset port here would only block mapping onto block RAM.
    always_ff @(posedge clk_in) begin
        if (pix_ok && grp_idx == '0)
            rd_q <= mem[addr];
        if (group_end)
            mem[addr] <= (row_idx == '0) ? grp : blk;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mode_q <= MODE_THRESH;
            thr_q  <= '0;
            primed <= 1'b0;
            h_acc  <= '0;
        end else if (pix_ok) begin
            if (bus.hcount_in == '0 && bus.vcount_in == '0) begin
                mode_q <= bus.mode_in;
                thr_q  <= bus.threshold_in;
            end
            if (grp_idx == '0 && row_idx == '0)
                primed <= 1'b1;
            h_acc <= (grp_idx == '0) ? pix_ext : grp;
        end
    end

    logic                  s1_valid, s2_valid, o_valid;
    logic                  s1_last,  s2_last,  o_last;
    logic [DATA_WIDTH-1:0] s1_pix,   s2_pix,   o_pix;
    logic [AWIDTH-1:0]     s1_h,     s2_h,     o_h;
    logic [BWIDTH-1:0]     s1_v,     s2_v,     o_v;

    // The result is formed at emission time, so a mode change at the next frame's (0,0)
    // cannot reach a block still travelling down the pipeline.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0; s1_last <= 1'b0; s1_pix <= '0; s1_h <= '0; s1_v <= '0;
            s2_valid <= 1'b0; s2_last <= 1'b0; s2_pix <= '0; s2_h <= '0; s2_v <= '0;
            o_valid  <= 1'b0; o_last  <= 1'b0; o_pix  <= '0; o_h  <= '0; o_v  <= '0;
        end else begin
            s1_valid <= emit;
            s1_last  <= emit && last_blk;
            if (emit) begin
                s1_pix <= res;
                s1_h   <= addr;
                s1_v   <= vblk;
            end
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_pix   <= s1_pix;
            s2_h     <= s1_h;
            s2_v     <= s1_v;
            o_valid  <= s2_valid;
            o_last   <= s2_last;
            if (s2_valid) begin
                o_pix <= s2_pix;
                o_h   <= s2_h;
                o_v   <= s2_v;
            end
        end
    end

    assign bus.data_valid_out = o_valid;
    assign bus.frame_done_out = o_last;
    assign bus.pixel_data_out = o_pix;
    assign bus.hcount_out     = o_h;
    assign bus.vcount_out     = o_v;
endmodule

// File: tb/tb_binning_n.sv
// Scoreboard bench for binning_n: two instances (K=4/1-bit and K=2/8-bit) on reduced rasters,
// frame images modelled as arrays, block results computed directly from the image.
`timescale 1ns/1ps
module tb_binning_n;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [7:0] d_h = '0;
    logic [7:0] d_v = '0;
    logic [7:0] d_pix = '0;
    logic       d_valid = 1'b0;
    logic [1:0] d_mode = '0;
    logic [15:0] d_thr = '0;
    int         sel = 0;

    // Instance A: 48x24, K=4, 1-bit.  Instance B: 12x8, K=2, 8-bit.
    binning_n_if #(.HRES(48), .VRES(24), .DATA_WIDTH(1), .KERNEL_SIZE(4)) ia ();
    binning_n_if #(.HRES(12), .VRES(8),  .DATA_WIDTH(8), .KERNEL_SIZE(2)) ib ();

    assign ia.hcount_in     = d_h[5:0];
    assign ia.vcount_in     = d_v[4:0];
    assign ia.pixel_data_in = d_pix[0];
    assign ia.data_valid_in = d_valid && (sel == 0);
    assign ia.mode_in       = d_mode;
    assign ia.threshold_in  = d_thr[4:0];

    assign ib.hcount_in     = d_h[3:0];
    assign ib.vcount_in     = d_v[2:0];
    assign ib.pixel_data_in = d_pix;
    assign ib.data_valid_in = d_valid && (sel == 1);
    assign ib.mode_in       = d_mode;
    assign ib.threshold_in  = d_thr[9:0];

    binning_n #(.HRES(48), .VRES(24), .DATA_WIDTH(1), .KERNEL_SIZE(4))
        dut_a (.clk_in(clk), .rst_in(rst_a), .bus(ia));
    binning_n #(.HRES(12), .VRES(8), .DATA_WIDTH(8), .KERNEL_SIZE(2))
        dut_b (.clk_in(clk), .rst_in(rst_b), .bus(ib));

    int P_H [2]    = '{48, 12};
    int P_V [2]    = '{24, 8};
    int P_K [2]    = '{4, 2};
    int P_DW [2]   = '{1, 8};
    int P_SMAX [2] = '{16, 1020};

    typedef struct {
        int pix;
        int hc;
        int vc;
        int done;
        int at;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   a_first_vc = -1;

    int   img [2][24][48];
    int   m_mode [2];
    int   m_thr [2];
    bit   m_primed [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: block result straight from the frame image and the frame's latched mode.
    function automatic int block_val(input int id, input int bh, input int bv);
        int k = P_K[id];
        int sum = 0;
        int mx = 0;
        for (int dy = 0; dy < k; dy++)
            for (int dx = 0; dx < k; dx++) begin
                int p = img[id][bv*k+dy][bh*k+dx];
                sum += p;
                if (p > mx) mx = p;
            end
        case (m_mode[id])
            1:       return sum / (k * k);
            2:       return mx;
            default: return (sum > m_thr[id]) ? (1 << P_DW[id]) - 1 : 0;
        endcase
    endfunction

    task automatic model_pixel(input int id, input int h, input int v);
        int k = P_K[id];
        exp_t e;
        if (h >= P_H[id] || v >= P_V[id]) return;
        if (h == 0 && v == 0) begin
            m_mode[id] = int'(d_mode);
            m_thr[id]  = int'(d_thr);
        end
        if (h % k == 0 && v % k == 0) m_primed[id] = 1'b1;
        if (h % k == k - 1 && v % k == k - 1 && m_primed[id]) begin
            e.pix  = block_val(id, h / k, v / k);
            e.hc   = h / k;
            e.vc   = v / k;
            e.done = (h / k == P_H[id] / k - 1 && v / k == P_V[id] / k - 1) ? 1 : 0;
            e.at   = cyc + 3;
            if (id == 0) qa.push_back(e);
            else         qb.push_back(e);
        end
    endtask

    task automatic drive(input int id, input int h, input int v, input int pix, input bit valid);
        @(negedge clk);
        sel     = id;
        d_h     = 8'(h);
        d_v     = 8'(v);
        d_pix   = 8'(pix);
        d_valid = valid;
        if (valid) model_pixel(id, h, v);
    endtask

    task automatic do_reset(input int id);
        @(negedge clk);
        #1;
        d_valid = 1'b0;
        if (id == 0) begin
            rst_a = 1'b1;
            qa.delete();
            a_first_vc = int'(d_v) / P_K[0] + 1;
        end else begin
            rst_b = 1'b1;
            qb.delete();
        end
        m_mode[id]   = 0;
        m_thr[id]    = 0;
        m_primed[id] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        if (id == 0) rst_a = 1'b0;
        else         rst_b = 1'b0;
    endtask

    task automatic fill(input int id);
        for (int v = 0; v < P_V[id]; v++)
            for (int h = 0; h < P_H[id]; h++)
                img[id][v][h] = int'($urandom_range(0, (1 << P_DW[id]) - 1));
    endtask

    task automatic run_frame(input int id, input int mode, input int thr, input int mid_mode,
                             input int rst_row, input bit inject);
        d_mode = 2'(mode);
        d_thr  = 16'(thr);
        for (int v = 0; v < P_V[id]; v++) begin
            if (mid_mode >= 0 && v == P_V[id] / 2) begin
                d_mode = 2'(mid_mode);
                d_thr  = 16'($urandom_range(0, P_SMAX[id]));
            end
            for (int h = 0; h < P_H[id]; h++) begin
                int gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                for (int g = 0; g < gaps; g++) drive(id, h, v, int'($urandom), 1'b0);
                if (inject && h == P_H[id] / 2) begin
                    drive(id, P_H[id] + int'($urandom_range(0, 15)), v, int'($urandom), 1'b1);
                    drive(id, int'($urandom_range(0, P_H[id] - 1)), P_V[id] + int'($urandom_range(0, 7)),
                          int'($urandom), 1'b1);
                end
                if (v == rst_row && h == P_H[id] / 3) do_reset(id);
                drive(id, h, v, img[id][v][h], 1'b1);
            end
        end
    endtask

    task automatic drain();
        @(negedge clk);
        d_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic compare_out(input string tag, input exp_t e, input int pix, input int hc,
                               input int vc, input int done);
        check({tag, "_pixel"}, pix, e.pix);
        check({tag, "_hcount"}, hc, e.hc);
        check({tag, "_vcount"}, vc, e.vc);
        check({tag, "_frame_done"}, done, e.done);
        check({tag, "_latency_cycle"}, cyc, e.at);
    endtask

    exp_t ea;
    exp_t eb;

    always @(negedge clk) begin
        while (qa.size() != 0 && qa[0].at < cyc) begin
            check("a_missing_output", 0, 1);
            void'(qa.pop_front());
        end
        if (ia.data_valid_out === 1'b1) begin
            if (a_first_vc >= 0) begin
                check("a_first_vcount_after_reset", int'(ia.vcount_out), a_first_vc);
                a_first_vc = -1;
            end
            if (qa.size() == 0) begin
                check("a_unexpected_output", 1, 0);
            end else begin
                ea = qa.pop_front();
                compare_out("a", ea, int'(ia.pixel_data_out), int'(ia.hcount_out),
                            int'(ia.vcount_out), int'(ia.frame_done_out));
            end
        end else if (ia.frame_done_out !== 1'b0) begin
            check("a_frame_done_without_valid", 1, 0);
        end
    end

    always @(negedge clk) begin
        while (qb.size() != 0 && qb[0].at < cyc) begin
            check("b_missing_output", 0, 1);
            void'(qb.pop_front());
        end
        if (ib.data_valid_out === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_unexpected_output", 1, 0);
            end else begin
                eb = qb.pop_front();
                compare_out("b", eb, int'(ib.pixel_data_out), int'(ib.hcount_out),
                            int'(ib.vcount_out), int'(ib.frame_done_out));
            end
        end else if (ib.frame_done_out !== 1'b0) begin
            check("b_frame_done_without_valid", 1, 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_thr[i] = 0; m_primed[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("a_reset_valid", int'(ia.data_valid_out), 0);
        check("a_reset_done",  int'(ia.frame_done_out), 0);
        check("a_reset_pixel", int'(ia.pixel_data_out), 0);
        check("a_reset_hcount", int'(ia.hcount_out), 0);
        check("a_reset_vcount", int'(ia.vcount_out), 0);
        check("b_reset_valid", int'(ib.data_valid_out), 0);
        check("b_reset_done",  int'(ib.frame_done_out), 0);
        check("b_reset_pixel", int'(ib.pixel_data_out), 0);
        check("b_reset_hcount", int'(ib.hcount_out), 0);
        check("b_reset_vcount", int'(ib.vcount_out), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);

        // A: block (0,0) all ones, (1,0) exactly 8 ones, (2,0) 9 ones, threshold 8.
        fill(0);
        for (int dy = 0; dy < 4; dy++)
            for (int dx = 0; dx < 4; dx++) begin
                img[0][dy][dx]     = 1;
                img[0][dy][4 + dx] = (dy * 4 + dx < 8) ? 1 : 0;
                img[0][dy][8 + dx] = (dy * 4 + dx < 9) ? 1 : 0;
            end
        run_frame(0, 0, 8, -1, -1, 1'b1);
        fill(0); run_frame(0, 1, 0, 2, -1, 1'b1);
        fill(0); run_frame(0, 2, 0, -1, -1, 1'b0);
        fill(0); run_frame(0, 3, int'($urandom_range(0, 16)), -1, -1, 1'b1);
        fill(0); run_frame(0, 1, 0, -1, 5, 1'b0);
        fill(0); run_frame(0, 0, int'($urandom_range(0, 16)), -1, -1, 1'b1);
        drain();
        check("a_queue_drained", qa.size(), 0);

        // B: block (0,0) = 10, 20 / 30, 41 -> mean 25, max 41.
        fill(1);
        img[1][0][0] = 10; img[1][0][1] = 20; img[1][1][0] = 30; img[1][1][1] = 41;
        run_frame(1, 1, 0, -1, -1, 1'b0);
        run_frame(1, 2, 0, -1, -1, 1'b0);
        run_frame(1, 0, int'($urandom_range(0, 1020)), 1, -1, 1'b0);
        fill(1); run_frame(1, 2, 0, 1, -1, 1'b0);
        fill(1); run_frame(1, 1, 0, -1, 3, 1'b0);
        fill(1); run_frame(1, 3, int'($urandom_range(0, 1020)), -1, -1, 1'b0);
        drain();
        check("b_queue_drained", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/binning_n.md
# binning_n

Parametrised raster-stream downsampler that reduces each KERNEL_SIZE×KERNEL_SIZE pixel block to one output pixel. It replaces the fixed 4×4, 1-bit majority binner in the vision front end. Instead of K full-resolution line buffers, it keeps one accumulator line of HRES/K entries. The reduction mode is selectable per frame: threshold, mean or max.

## Interface
- HRES, 1280: input active width; must be a multiple of KERNEL_SIZE.
- VRES, 720: input active height; must be a multiple of KERNEL_SIZE.
- DATA_WIDTH, 1: input and output pixel width, 1..8.
- KERNEL_SIZE, 4: block edge K; power of two, 2..8; LK = log2(K).
- Derived: HWIDTH = $clog2(HRES), VWIDTH = $clog2(VRES), SUM_WIDTH = DATA_WIDTH + 2·LK.
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- hcount_in  input  HWIDTH  column of the incoming pixel.
- vcount_in  input  VWIDTH  row of the incoming pixel.
- pixel_data_in  input  DATA_WIDTH  incoming pixel.
- data_valid_in  input  1  pixel qualifier.
- mode_in  input  2  0 = threshold, 1 = mean, 2 = max, 3 = reserved (treated as threshold).
- threshold_in  input  SUM_WIDTH  threshold for mode 0.
- pixel_data_out  output  DATA_WIDTH  binned pixel.
- hcount_out  output  HWIDTH-LK  output column.
- vcount_out  output  VWIDTH-LK  output row.
- data_valid_out  output  1  one-cycle qualifier for the output fields.
- frame_done_out  output  1  one-cycle pulse, coincident with the last block of the frame.

## Operation
- Input arrives in raster order. Valid pixels may have gaps; there is no backpressure.
- Pixels with hcount_in ≥ HRES or vcount_in ≥ VRES are ignored.
- Horizontal stage: a running register folds the K pixels of a group, selected by hcount_in[LK-1:0] = 0..K-1.
  - Sum in modes 0/1; max in mode 2.
  - The register restarts on group index 0.
- Vertical stage: the group result is written to accumulator entry hcount_in>>LK when group index is K-1.
  - Block row index vcount_in[LK-1:0] = 0: the entry is overwritten.
  - Otherwise the group result is folded into the existing entry (sum or max).
- Emission: on the group completing at row index K-1, the block result F is formed from the entry plus the final group.
  - Mode 0: all-ones if F > threshold_in (strict), else 0.
  - Mode 1: F >> (2·LK), i.e. the truncated mean.
  - Mode 2: F directly.
  - hcount_out = hcount>>LK and vcount_out = vcount>>LK of the triggering pixel.
- Mode latch: mode_in and threshold_in are sampled on the valid pixel at (0,0). They hold for the whole frame; mid-frame changes are ignored.
- Sums never overflow, because SUM_WIDTH covers K²·(2^DATA_WIDTH − 1).
- Accumulator memory is not reset; row-index-0 overwrite makes stale contents harmless.
- Prime guard:
  - A "primed" flag clears on reset and sets on the first valid pixel with row index 0 and group index 0.
  - Emission is suppressed until primed. A reset mid-block therefore never outputs a partial block.
- frame_done_out asserts with the output at (HRES/K − 1, VRES/K − 1).

## Timing
- Reset values: data_valid_out = 0, frame_done_out = 0, pixel_data_out = 0, hcount_out = 0, vcount_out = 0. Latched mode = 0, latched threshold = 0, primed = 0.
- Latency: data_valid_out asserts exactly 3 clk_in cycles after the valid input cycle that completes a block. Output fields are stable only while data_valid_out = 1.
- Throughput: one input pixel per cycle, sustained at K = 2.
  - The accumulator read for a group issues at group index 0 and must be ready by group index K-1.
  - Read-after-write to the same entry cannot collide, since addresses advance every K ≥ 2 pixels.
- Outputs are at most one per K input cycles and never back-to-back when K ≥ 2.
- Reset asserted mid-frame clears pending pipeline valids immediately. No output from in-flight blocks appears after reset release.

## Test plan
- K=4, DW=1, mode 0, threshold 8; block (0,0) all ones → one pulse: pixel_data_out = 1, hcount_out = 0, vcount_out = 0, 3 cycles after input (3,3).
- Same configuration with exactly 8 ones in the block → pixel_data_out = 0 (strict compare). With 9 ones → 1.
- K=2, DW=8, block values 10, 20, 30, 41:
  - Mode 1 → pixel_data_out = 25.
  - Same data, mode 2, in the next frame → 41.
  - Mode switched mid-frame → no change until the next (0,0).
- K=4: reset pulsed during input row 5 and released → no data_valid_out until rows 8..11 complete; first output has vcount_out = 2.
- Full 1280×720 frame, K=4, with random valid gaps → exactly 320×180 outputs in raster order, matching a golden model per mode. frame_done_out pulses once, with hcount_out = 319, vcount_out = 179.
- Pixels with hcount_in ≥ 1280 injected mid-row → ignored; output values are unchanged.
